// File: rtl/kyber_coef_io_seq.sv
// kyber_coef_io_seq: streams one 256-coefficient polynomial into or out of the
// two-sided coefficient banks (BR1/BR2) in natural or NTT-interleaved layout.
// Ports: clk, reset (async, active-low); load_start/read_start/mode start an
// operation; din/din_valid carry load beats; dout/out_valid/out_ready carry
// read beats; bram_* drive the banks; busy/done report status.
module kyber_coef_io_seq #(
  parameter int PE_NUMBER = 1,
  parameter int W = 12,
  parameter int AW = $clog2(128 / PE_NUMBER)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    read_start,
  input  logic                    mode,
  input  logic [W*PE_NUMBER-1:0]  din,
  input  logic                    din_valid,
  output logic [W*PE_NUMBER-1:0]  dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    bram_we,
  output logic                    bram_re,
  output logic                    bram_sel,
  output logic [AW-1:0]           bram_addr,
  output logic [W*PE_NUMBER-1:0]  bram_wdata,
  input  logic [W*PE_NUMBER-1:0]  bram_rdata,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = W * PE_NUMBER;
  localparam int BW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] b;
  logic          mode_q;
  logic          inflight;
  logic [1:0]    fcnt;
  logic          wptr;
  logic          rptr;
  logic [DW-1:0] mem [2];
  logic          done_q;

  logic          act;
  logic          pop;
  logic          issue;
  logic          last;
  logic [2:0]    occ;
  logic [AW-1:0] row_ntt;
  logic [AW-1:0] row_nat;

  assign act  = (state == LOAD) || (state == READ);
  assign last = (b == '1);
  assign pop  = out_valid & out_ready;

  // Slots already claimed: buffered beats plus the read still in the bank.
  // A beat popped this cycle frees its slot for an issue in the same cycle.
  assign occ   = {1'b0, fcnt} + {2'b0, inflight};
  assign issue = (state == READ) && (occ < 3'd2 + {2'b0, pop});

  // In both layouts the bank side is the beat LSB; the NTT order
  // {0,2,1,3} only swaps which of b[1:0] selects the row LSB.
  assign row_ntt = {b[BW-1:2], b[1]};
  assign row_nat = b[BW-1:1];

  assign bram_sel   = act & b[0];
  assign bram_addr  = act ? (mode_q ? row_ntt : row_nat) : '0;
  assign bram_we    = (state == LOAD) & din_valid;
  assign bram_re    = issue;
  assign bram_wdata = (state == LOAD) ? din : '0;

  assign out_valid = (fcnt != 2'd0);
  assign dout      = out_valid ? mem[rptr] : '0;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      b        <= '0;
      mode_q   <= 1'b0;
      inflight <= 1'b0;
      fcnt     <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (inflight) begin
        mem[wptr] <= bram_rdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fcnt <= fcnt + {1'b0, inflight} - {1'b0, pop};
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state  <= LOAD;
            mode_q <= mode;
            b      <= '0;
          end else if (read_start) begin
            state  <= READ;
            mode_q <= mode;
            b      <= '0;
          end
        end
        LOAD: begin
          if (din_valid) begin
            b <= b + 1'b1;
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            b <= b + 1'b1;
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && (fcnt == {1'b0, pop})) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_coef_io_seq.sv
// Bench for kyber_coef_io_seq: directed loads/reads on a P=1 and a P=2 instance,
// with bank model and scoreboard queues checked by a negedge monitor.
module tb_kyber_coef_io_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_start, read_start, mode, din_valid, out_ready;
  logic [11:0] din, dout, bram_wdata;
  logic [11:0] bram_rdata = '0;
  logic        out_valid, bram_we, bram_re, bram_sel, busy, done;
  logic [6:0]  bram_addr;

  logic        load_start2, mode2, din_valid2;
  logic        read_start2, out_ready2;
  logic [23:0] din2, dout2, wdata2, rdata2;
  logic        out_valid2, we2, re2, sel2, busy2, done2;
  logic [5:0]  addr2;

  assign read_start2 = 1'b0;
  assign out_ready2  = 1'b1;
  assign rdata2      = '0;

  kyber_coef_io_seq #(.PE_NUMBER(1)) u1 (
    .clk(clk), .reset(reset),
    .load_start(load_start), .read_start(read_start), .mode(mode),
    .din(din), .din_valid(din_valid),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .bram_we(bram_we), .bram_re(bram_re), .bram_sel(bram_sel),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .busy(busy), .done(done)
  );

  kyber_coef_io_seq #(.PE_NUMBER(2)) u2 (
    .clk(clk), .reset(reset),
    .load_start(load_start2), .read_start(read_start2), .mode(mode2),
    .din(din2), .din_valid(din_valid2),
    .dout(dout2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bram_we(we2), .bram_re(re2), .bram_sel(sel2),
    .bram_addr(addr2), .bram_wdata(wdata2),
    .bram_rdata(rdata2), .busy(busy2), .done(done2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [11:0] bank [2][128];
  always @(posedge clk) begin
    if (bram_we) bank[bram_sel][bram_addr] = bram_wdata;
    if (bram_re) bram_rdata <= bank[bram_sel][bram_addr];
  end

  logic [19:0] wq [$];
  logic [11:0] rq [$];
  logic [30:0] wq2 [$];

  int  re_cnt = 0, pops = 0, first_v = -1;
  int  done_cyc = -1, done_cyc2 = -1;
  bit  done_seen = 0, done_seen2 = 0, done_busy = 0;
  bit  stall_prev = 0;
  logic [11:0] stall_dout = '0;

  always @(negedge clk) begin
    logic [19:0] e;
    logic [30:0] e2;
    logic [11:0] r;
    if (bram_we) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got sel=%0d addr=%0d data=%0h, want none",
                 bram_sel, bram_addr, bram_wdata);
      end else begin
        e = wq.pop_front();
        if ({bram_re, bram_sel, bram_addr, bram_wdata} !== {1'b0, e}) begin
          miscompares++;
          $display("FAIL wr: got re=%0d sel=%0d addr=%0d data=%0h, want re=0 sel=%0d addr=%0d data=%0h",
                   bram_re, bram_sel, bram_addr, bram_wdata, e[19], e[18:12], e[11:0]);
        end
      end
    end
    if (bram_re) re_cnt++;
    if (stall_prev) begin
      vectors++;
      if (!out_valid || dout !== stall_dout) begin
        miscompares++;
        $display("FAIL hold: got valid=%0d dout=%0h, want valid=1 dout=%0h",
                 out_valid, dout, stall_dout);
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_dout = dout;
    if (out_valid && first_v < 0) first_v = cyc;
    if (out_valid && out_ready) begin
      vectors++;
      pops++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got dout=%0h, want none", dout);
      end else begin
        r = rq.pop_front();
        if (dout !== r) begin
          miscompares++;
          $display("FAIL rd: got dout=%0h, want %0h", dout, r);
        end
      end
    end
    if (done) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (we2) begin
      vectors++;
      if (wq2.size() == 0) begin
        miscompares++;
        $display("FAIL wr2_unexpected: got addr=%0d data=%0h, want none", addr2, wdata2);
      end else begin
        e2 = wq2.pop_front();
        if ({sel2, addr2, wdata2} !== e2) begin
          miscompares++;
          $display("FAIL wr2: got sel=%0d addr=%0d data=%0h, want sel=%0d addr=%0d data=%0h",
                   sel2, addr2, wdata2, e2[30], e2[29:24], e2[23:0]);
        end
      end
    end
    if (done2) begin
      done_seen2 = 1;
      done_cyc2  = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n;
    n = 0;
    while (!done_seen && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no done, want done within %0d cycles", nm, limit);
    end
  endtask

  task automatic start_read(input logic m, output int t);
    done_seen = 0;
    first_v = -1;
    pops = 0;
    read_start = 1; mode = m; t = cyc;
    @(posedge clk); #1;
    read_start = 0;
  endtask

  int stab [4] = '{0, 2, 1, 3};

  initial begin
    int g, s, c, t, re0, n, b, k;
    reset = 0;
    load_start = 0; read_start = 0; mode = 0;
    din = '0; din_valid = 0; out_ready = 1;
    load_start2 = 0; mode2 = 0; din2 = '0; din_valid2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_strobes", 32'({bram_we, bram_re, bram_sel, bram_addr}), 0);
    chk("rst_wdata", 32'(bram_wdata), 0);
    chk("rst2_busy", 32'({busy2, we2, done2}), 0);
    reset = 1;
    @(posedge clk); #1;

    // NTT load 0..255 with simultaneous read_start and a stray read_start mid-load
    done_seen = 0; re0 = re_cnt;
    load_start = 1; read_start = 1; mode = 1; t = cyc;
    @(posedge clk); #1;
    load_start = 0; read_start = 0;
    for (int i = 0; i < 256; i++) begin
      g = i / 4; s = stab[i % 4]; c = 4 * g + s;
      din = 12'(c); din_valid = 1;
      read_start = (i == 10);
      wq.push_back({1'(s / 2), 7'(2 * g + s % 2), 12'(c)});
      @(posedge clk); #1;
    end
    din_valid = 0; read_start = 0;
    wait_done(20, "load_ntt_done");
    chk("load_ntt_done_cyc", 32'(done_cyc), 32'(t + 257));
    chk("load_ntt_busy_at_done", 32'(done_busy), 0);
    chk("load_no_reads", 32'(re_cnt - re0), 0);
    chk("load_ntt_wq_empty", 32'(wq.size()), 0);

    // NTT read of what was just loaded
    for (int i = 0; i < 256; i++) begin
      g = i / 4; s = stab[i % 4];
      rq.push_back(12'(4 * g + s));
    end
    out_ready = 1;
    start_read(1'b1, t);
    wait_done(400, "read_ntt_done");
    chk("read_ntt_first_valid", 32'(first_v), 32'(t + 3));
    chk("read_ntt_done_cyc", 32'(done_cyc), 32'(t + 259));
    chk("read_ntt_rq_empty", 32'(rq.size()), 0);

    // Natural read from BR1[r]=r, BR2[r]=128+r
    for (int r = 0; r < 128; r++) begin
      bank[0][r] = 12'(r);
      bank[1][r] = 12'(128 + r);
    end
    for (int i = 0; i < 256; i++) rq.push_back(12'((i / 2) + 128 * (i % 2)));
    start_read(1'b0, t);
    wait_done(400, "read_nat_done");
    chk("read_nat_first_valid", 32'(first_v), 32'(t + 3));
    chk("read_nat_done_cyc", 32'(done_cyc), 32'(t + 259));
    chk("read_nat_rq_empty", 32'(rq.size()), 0);

    // Natural read under random backpressure
    for (int i = 0; i < 256; i++) rq.push_back(12'((i / 2) + 128 * (i % 2)));
    start_read(1'b0, t);
    n = 0;
    while (!done_seen && n < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1;
    chk("read_bp_done_seen", 32'(done_seen), 1);
    chk("read_bp_pops", 32'(pops), 256);
    chk("read_bp_rq_empty", 32'(rq.size()), 0);

    // Reset at beat 50 of a read
    for (int i = 0; i < 256; i++) rq.push_back(12'((i / 2) + 128 * (i % 2)));
    start_read(1'b0, t);
    n = 0;
    while (pops < 50 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_reached_50", 32'(pops), 50);
    #2;
    reset = 0;
    #1;
    chk("rst_mid_valid_dout", 32'({out_valid, dout}), 0);
    chk("rst_mid_strobes", 32'({bram_we, bram_re, bram_sel, bram_addr}), 0);
    chk("rst_mid_busy_done", 32'({busy, done}), 0);
    chk("rst_mid_wdata", 32'(bram_wdata), 0);
    rq.delete();
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_after_valid", 32'({out_valid, busy}), 0);

    // Natural load with din_valid low every 3rd cycle
    done_seen = 0; re0 = re_cnt;
    load_start = 1; mode = 0;
    @(posedge clk); #1;
    load_start = 0;
    b = 0; k = 0;
    while (b < 256 && k < 1000) begin
      if (k % 3 == 2) din_valid = 0;
      else begin
        din_valid = 1;
        din = 12'(b * 7 + 3);
        wq.push_back({1'(b % 2), 7'(b / 2), 12'(b * 7 + 3)});
        b++;
      end
      @(posedge clk); #1;
      k++;
    end
    din_valid = 0;
    wait_done(20, "load_gap_done");
    chk("load_gap_wq_empty", 32'(wq.size()), 0);
    chk("load_gap_no_reads", 32'(re_cnt - re0), 0);
    chk("load_gap_busy_at_done", 32'(done_busy), 0);

    // P=2 NTT load
    load_start2 = 1; mode2 = 1; t = cyc;
    @(posedge clk); #1;
    load_start2 = 0;
    for (int i = 0; i < 128; i++) begin
      g = i / 4; s = stab[i % 4];
      din2 = {12'(4 * (2 * g + 1) + s), 12'(4 * (2 * g) + s)};
      din_valid2 = 1;
      wq2.push_back({1'(s / 2), 6'(2 * g + s % 2), din2});
      @(posedge clk); #1;
    end
    din_valid2 = 0;
    n = 0;
    while (!done_seen2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("p2_done_cyc", 32'(done_cyc2), 32'(t + 129));
    chk("p2_wq_empty", 32'(wq2.size()), 0);
    chk("p2_busy_after", 32'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kyber_coef_io_seq.md
# kyber_coef_io_seq

Parametrised coefficient I/O sequencer for the Kyber polynomial-multiplier datapath with `PE_NUMBER` lanes. It streams one polynomial (256 × 12-bit coefficients) from the host into the two-sided coefficient BRAM banks in either NTT-interleaved or natural layout. It also streams a stored polynomial back out in either layout, with valid/ready backpressure over the 1-cycle BRAM read latency. It replaces the fixed single-PE load/read counters in the top-level controller.

## Interface
- `PE_NUMBER`, 1: lanes per beat; power of two, 1..8; each bank side is `128/PE_NUMBER` deep.
- `W`, 12: coefficient width.
- `AW`, $clog2(128/PE_NUMBER): bank address width; minimum 1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse; begins a load (ignored unless IDLE).
- `read_start`  in  1  one-cycle pulse; begins a read (ignored unless IDLE; `load_start` wins if both are high).
- `mode`  in  1  sampled with the start pulse; 0 = natural layout, 1 = NTT-interleaved layout.
- `din`  in  W*PE_NUMBER  load beat; lane j = bits [W*j +: W].
- `din_valid`  in  1  beat present; the block always accepts in LOAD.
- `dout`  out  W*PE_NUMBER  read beat.
- `out_valid`  out  1  `dout` valid.
- `out_ready`  in  1  sink accepts `dout`.
- `bram_we`, `bram_re`  out  1  bank write / read strobe.
- `bram_sel`  out  1  bank side (0 = BR1, 1 = BR2).
- `bram_addr`  out  AW  bank row.
- `bram_wdata`  out  W*PE_NUMBER  write data (lane j → PE j bank).
- `bram_rdata`  in  W*PE_NUMBER  read data, valid 1 cycle after `bram_re`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a load or read.

## Operation
- States: IDLE → LOAD (on `load_start`) → IDLE; IDLE → READ (on `read_start`) → DRAIN (all reads issued) → IDLE (output buffer empty).
- Beat counter `b` runs 0..256/PE_NUMBER−1. Let P = PE_NUMBER.
- NTT layout (mode=1): g = b>>2; q = b[1:0]; s = {0,2,1,3}[q]. Lane j carries coefficient 4(gP+j)+s. Side = s[1]; row = 2g+s[0].
- Natural layout (mode=0): m = b>>1; side = b[0]; row = m. Lane j carries coefficient mP+j+128·side.
- LOAD: `bram_we` = `din_valid`. `bram_sel` and `bram_addr` come combinationally from `b`; `bram_wdata` = `din`. `b` increments per valid beat. Gaps in `din_valid` are legal.
- READ: the same mapping drives `bram_re`. Read data enters a 2-entry FIFO; `dout` and `out_valid` are driven from the FIFO head.
- Issue rule: a read issues when count + inflight − pop < 2, where pop = `out_valid & out_ready`. The FIFO therefore never overflows, and no beat is lost or duplicated under any `out_ready` pattern.
- Start pulses outside IDLE are ignored and do not affect the running operation.
- Reset (any time, including mid-operation): state → IDLE, counters and FIFO cleared, in-flight read data discarded.

## Timing
- Reset values: all outputs 0; `dout` = 0.
- Load with a start pulse in cycle T: beats are accepted from T+1. With `din_valid` high continuously, `done` pulses at T+1+256/P and `busy` falls in that same cycle.
- Read with a start pulse in cycle T: the first `bram_re` is at T+1 and the first `out_valid` is at T+3.
- With `out_ready` held high, throughput is 1 beat per cycle. The last beat is presented at T+2+256/P; `done` pulses the cycle after the last pop.
- When `out_ready` is low, `dout` and `out_valid` are held stable.
- `bram_we` and `bram_re` are never asserted in the same cycle.

## Test plan
- P=1, NTT load of values 0..255 (stream 0,2,1,3,4,…): bank writes go to (side, row) = (0,0)=0, (1,0)=2, (0,1)=1, (1,1)=3; `done` pulses at T+257.
- P=1, natural read of a bank model holding BR1[r]=r, BR2[r]=128+r, with `out_ready`=1: `dout` sequence is 0,128,1,129,…,127,255 and the first `out_valid` is at T+3.
- P=2, NTT load: beat 0 has lanes {0,4} at side 0 row 0; beat 3 has lanes {3,7} at side 1 row 1; 128 beats in total.
- Natural read with `out_ready` toggling 1,0,0,1 pseudo-randomly: all 256/P beats arrive exactly once in order, the FIFO never holds more than 2 entries, and `dout` is stable while stalled.
- `load_start` and `read_start` in the same cycle → LOAD. A `read_start` pulse during LOAD is ignored and the load completes normally.
- `reset` low at beat 50 of a read: all outputs are 0 the same cycle. After release, a new load with `din_valid` gapped every 3rd cycle completes with correct addresses.
